// File: rtl/miriscv_lsu.sv
// Load-store unit: issues data-memory requests for decoder memory micro-ops,
// stalls the core until the access completes and returns extended load data.
module miriscv_lsu #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] lsu_data_q, lsu_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        to_err_q, to_err_d;

    logic        size_ok, misaligned, bad_access, issue, timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        size_ok = 1'b0;
        case (lsu_size_i)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !lsu_we_i;
            default:                size_ok = 1'b0;
        endcase
    end

    assign misaligned = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                        ((lsu_size_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
    assign bad_access = !size_ok || misaligned;
    assign issue      = (state_q == IDLE) && lsu_req_i && !bad_access;
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        be    = 4'b1111;
        wdata = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be    = 4'b0001 << lsu_addr_i[1:0];
                wdata = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata = {2{lsu_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = data_rdata_i[{lsu_addr_i[1:0], 3'b000} +: 8];
    assign ld_half = data_rdata_i[{lsu_addr_i[1], 4'b0000} +: 16];

    always_comb begin
        case (lsu_size_i)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = data_rdata_i;
        endcase
    end

    // The counter spans REQ and WAIT together; a response in the last
    // allowed WAIT cycle still completes, a grant in the last REQ cycle does not.
    always_comb begin
        state_d    = state_q;
        lsu_data_d = lsu_data_q;
        cnt_d      = cnt_q;
        to_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = data_gnt_i ? WAIT : REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (timeout_hit) begin
                    state_d  = DONE;
                    to_err_d = 1'b1;
                end else if (data_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (data_rvalid_i) begin
                    state_d = DONE;
                    if (!lsu_we_i) lsu_data_d = ld_data;
                end else if (timeout_hit) begin
                    state_d  = DONE;
                    to_err_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lsu_data_q <= '0;
            cnt_q      <= '0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lsu_data_q <= lsu_data_d;
            cnt_q      <= cnt_d;
            to_err_q   <= to_err_d;
        end
    end

    assign lsu_data_o      = lsu_data_q;
    assign lsu_stall_req_o = lsu_req_i && (state_q != DONE) && !bad_access;
    assign lsu_err_o       = ((state_q == IDLE) && lsu_req_i && bad_access) ||
                             ((state_q == DONE) && to_err_q);
    assign data_req_o      = issue || (state_q == REQ);
    assign data_we_o       = lsu_req_i && lsu_we_i;
    assign data_be_o       = lsu_req_i ? be : '0;
    assign data_addr_o     = lsu_req_i ? {lsu_addr_i[31:2], 2'b00} : '0;
    assign data_wdata_o    = lsu_req_i ? wdata : '0;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu: one instance with the timeout disabled,
// one with TIMEOUT=4; a monitor checks whichever instance is selected.
module tb_miriscv_lsu;

    localparam int unsigned TO1   = 4;
    localparam int unsigned NEVER = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req [2];
    logic        we, gnt, rvalid;
    logic [2:0]  size;
    logic [31:0] addr, wdata_in, rdata;

    logic [31:0] ldata [2];
    logic        stall [2];
    logic        err   [2];
    logic        dreq  [2];
    logic        dwe   [2];
    logic [3:0]  dbe   [2];
    logic [31:0] daddr [2];
    logic [31:0] dwdata[2];

    miriscv_lsu #(.TIMEOUT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req[0]), .lsu_we_i(we),
        .lsu_size_i(size), .lsu_addr_i(addr), .lsu_data_i(wdata_in),
        .lsu_data_o(ldata[0]), .lsu_stall_req_o(stall[0]), .lsu_err_o(err[0]),
        .data_req_o(dreq[0]), .data_we_o(dwe[0]), .data_be_o(dbe[0]),
        .data_addr_o(daddr[0]), .data_wdata_o(dwdata[0]),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata)
    );

    miriscv_lsu #(.TIMEOUT(TO1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req[1]), .lsu_we_i(we),
        .lsu_size_i(size), .lsu_addr_i(addr), .lsu_data_i(wdata_in),
        .lsu_data_o(ldata[1]), .lsu_stall_req_o(stall[1]), .lsu_err_o(err[1]),
        .data_req_o(dreq[1]), .data_we_o(dwe[1]), .data_be_o(dbe[1]),
        .data_addr_o(daddr[1]), .data_wdata_o(dwdata[1]),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata)
    );

    typedef struct {
        bit          err;
        int unsigned stall_cyc;
        int unsigned req_cyc;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          upd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_data [2];
    int unsigned sel = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got %0h, want %0h at %0t", nm, sel, act, want, $time);
        end
    endtask

    // Reference: what the access should look like from the outside, given
    // the memory's grant delay gd and response delay rdl (cycles after grant).
    function automatic exp_t model(input int unsigned to, input bit w, input logic [2:0] sz,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] rd, input int unsigned gd,
                                   input int unsigned rdl);
        exp_t        e;
        int unsigned nbytes, lane, need;
        logic [31:0] v;
        bit          legal;
        e.err = 0; e.stall_cyc = 0; e.req_cyc = 0; e.we = 0; e.be = '0;
        e.addr = '0; e.wdata = '0; e.upd = 0; e.data = '0;
        nbytes = 1 << sz[1:0];
        legal  = (sz == 3'd0 || sz == 3'd1 || sz == 3'd2 ||
                  (!w && (sz == 3'd4 || sz == 3'd5))) && (a % nbytes == 0);
        if (!legal) begin
            e.err = 1;
            return e;
        end
        lane    = a % 4;
        e.we    = w;
        e.addr  = a - lane;
        e.be    = (nbytes == 4) ? 4'hF : 4'(((1 << nbytes) - 1) << lane);
        e.wdata = (nbytes == 1) ? d[7:0] * 32'h0101_0101 :
                  (nbytes == 2) ? d[15:0] * 32'h0001_0001 : d;
        need = gd + rdl;
        if (to != 0 && need > to) begin
            e.err       = 1;
            e.stall_cyc = 1 + to;
            e.req_cyc   = 1 + ((gd < to) ? gd : to);
            return e;
        end
        e.stall_cyc = 1 + need;
        e.req_cyc   = 1 + gd;
        if (!w) begin
            v = rd >> (8 * lane);
            if (nbytes == 1)      v = (sz[2] || !v[7])  ? (v & 32'hFF)   : (v | 32'hFFFF_FF00);
            else if (nbytes == 2) v = (sz[2] || !v[15]) ? (v & 32'hFFFF) : (v | 32'hFFFF_0000);
            e.upd  = 1;
            e.data = v;
        end
        return e;
    endfunction

    // Monitor
    int unsigned m_cyc, m_req;
    bit          m_in = 0, m_cap, m_err_early;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    exp_t        m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_in        = 0;
            exp_data[0] = '0;
            exp_data[1] = '0;
        end else if (!req[sel]) begin
            chk("idle_outputs", {dreq[sel], stall[sel], err[sel], dwe[sel], dbe[sel],
                                 daddr[sel], dwdata[sel]}, '0);
            chk("idle_data", ldata[sel], exp_data[sel]);
        end else begin
            if (!m_in) begin
                m_in = 1; m_cyc = 0; m_req = 0; m_cap = 0; m_err_early = 0;
            end
            m_cyc++;
            if (dreq[sel]) begin
                m_req++;
                if (!m_cap) begin
                    m_cap = 1; m_we = dwe[sel]; m_be = dbe[sel];
                    m_addr = daddr[sel]; m_wdata = dwdata[sel];
                end
            end
            if (stall[sel]) begin
                if (err[sel]) m_err_early = 1;
            end else begin
                m_in = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("err", err[sel], m_e.err);
                    chk("err_while_stalled", m_err_early, 0);
                    chk("stall_cycles", m_cyc - 1, m_e.stall_cyc);
                    chk("req_cycles", m_req, m_e.req_cyc);
                    chk("no_reissue", dreq[sel], 0);
                    if (m_e.req_cyc > 0)
                        chk("req_fields", {m_we, m_be, m_addr}, {m_e.we, m_e.be, m_e.addr});
                    if (m_e.req_cyc > 0 && m_e.we)
                        chk("wdata", m_wdata, m_e.wdata);
                    if (m_e.upd) exp_data[sel] = m_e.data;
                    chk("load_data", ldata[sel], exp_data[sel]);
                end
            end
        end
    end

    // Stimulus (all tasks start and end just after a rising edge)
    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            we = 1'($urandom); size = 3'($urandom); addr = $urandom;
            wdata_in = $urandom; rdata = $urandom;
            gnt = 1'($urandom); rvalid = 1'($urandom);
            @(posedge clk); #1;
        end
        gnt = 0; rvalid = 0;
    endtask

    task automatic run_txn(input int unsigned s, input bit w, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                           input int unsigned gd, input int unsigned rdl);
        int unsigned k;
        bit          done;
        exp_q.push_back(model((s == 1) ? TO1 : 0, w, sz, a, d, rd, gd, rdl));
        sel = s;
        we = w; size = sz; addr = a; wdata_in = d; rdata = rd;
        req[s] = 1'b1;
        k = 0; done = 0;
        while (!done && k < 40) begin
            gnt    = (k == gd);
            rvalid = (k == gd + rdl);
            @(negedge clk);
            if (!stall[s]) done = 1;
            @(posedge clk); #1;
            k++;
        end
        req[s] = 1'b0; gnt = 0; rvalid = 0;
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL txn_bound (dut%0d): stall still 1 after 40 cycles, want 0", s);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            rst = 1; @(posedge clk); #1; rst = 0;
        end
    endtask

    task automatic rand_txn(input int unsigned s);
        bit          w;
        logic [2:0]  sz;
        logic [31:0] a;
        w  = ($urandom_range(0, 2) == 0);
        sz = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) begin
            sz = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            if (sz == 3'd3) sz = 3'd5;
        end
        a = $urandom;
        if ($urandom_range(0, 2) != 0) a = a & (32'hFFFF_FFFF << sz[1:0]);
        run_txn(s, w, sz, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
    endtask

    task automatic reset_mid_wait();
        sel = 0; we = 0; size = 3'b010; addr = 32'h300; rdata = 32'h5555_AAAA;
        req[0] = 1'b1; gnt = 1; rvalid = 0;
        @(posedge clk); #1;
        gnt = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0; req[0] = 1'b0; rvalid = 1;
        @(posedge clk); #1;
        rvalid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req[0] = 0; req[1] = 0; we = 0; size = '0; addr = '0; wdata_in = '0;
        gnt = 0; rvalid = 0; rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle(2);

        run_txn(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
        idle(1);
        run_txn(0, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
        run_txn(0, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
        run_txn(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 3, 1);
        run_txn(0, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1);
        run_txn(0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1);
        run_txn(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1);
        run_txn(0, 0, 3'b101, 32'h103, 32'h0, 32'h0, 0, 1);
        run_txn(0, 0, 3'b001, 32'h042, 32'h0, 32'hC001_7FFF, 1, 2);
        reset_mid_wait();
        idle(2);

        run_txn(1, 0, 3'b010, 32'h040, 32'h0, 32'h1111_2222, NEVER, 1);
        run_txn(1, 0, 3'b010, 32'h044, 32'h0, 32'h3333_4444, 0, NEVER);
        run_txn(1, 0, 3'b001, 32'h046, 32'h0, 32'h8765_4321, 2, 2);
        run_txn(1, 0, 3'b000, 32'h047, 32'h0, 32'h9ABC_DEF0, 2, 3);
        run_txn(1, 1, 3'b010, 32'h048, 32'hCAFE_F00D, 32'h0, 3, 1);
        idle(2);

        for (int i = 0; i < 200; i++) begin
            rand_txn(0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        for (int i = 0; i < 40; i++) begin
            rand_txn(1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
